// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - field codes, wrap limits and widths for the time-update datapath
package time_pkg;

    localparam int W_AB  = 6;
    localparam int W_SEC = 6;
    localparam int W_MIN = 6;
    localparam int W_HR  = 5;

    localparam logic [W_AB-1:0] SEC_MAX = 6'd59;
    localparam logic [W_AB-1:0] MIN_MAX = 6'd59;
    localparam logic [W_AB-1:0] HR_MAX  = 6'd23;

    typedef enum logic [1:0] {
        F_SEC  = 2'd0,
        F_MIN  = 2'd1,
        F_HR   = 2'd2,
        F_NONE = 2'd3
    } field_e;

    // Last legal value of a field; the "none" selector maps to zero.
    function automatic logic [W_AB-1:0] field_limit(input logic [1:0] f);
        logic [W_AB-1:0] lim;
        case (f)
            F_SEC:   lim = SEC_MAX;
            F_MIN:   lim = MIN_MAX;
            F_HR:    lim = HR_MAX;
            default: lim = '0;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/wrap_incr.sv
// rtl/wrap_incr.sv - increment with wrap to zero once the value reaches its limit
module wrap_incr
    import time_pkg::*;
(
    input  logic [W_AB-1:0] value_i,
    input  logic [W_AB-1:0] limit_i,
    output logic [W_AB-1:0] next_o,
    output logic            wrap_o
);

    // Equality (not >=) is the wrap condition, matching the controller's A==B test.
    always_comb begin
        wrap_o = (value_i == limit_i);
        next_o = wrap_o ? '0 : value_i + 6'd1;
    end

endmodule

// File: rtl/time_update_datapath.sv
// rtl/time_update_datapath.sv - hh:mm:ss register file driven by the time-update controller strobes
module time_update_datapath
    import time_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       s,
    input  logic             Kc,
    input  logic             La,
    input  logic             Lb,
    input  logic             Ea,
    input  logic             Lr,
    input  logic             Er,
    input  logic             set_valid,
    input  logic [1:0]       set_field,
    input  logic [5:0]       set_value,
    output logic             set_ready,
    output logic             u,
    output logic             busy,
    output logic             day_tick,
    output logic [W_HR-1:0]  hh,
    output logic [W_MIN-1:0] mm,
    output logic [W_SEC-1:0] ss,
    output logic [W_HR-1:0]  disp_hh,
    output logic [W_MIN-1:0] disp_mm,
    output logic [W_SEC-1:0] disp_ss
);

    logic [W_AB-1:0]  a_q, a_d;
    logic [W_AB-1:0]  b_q, b_d;
    logic             c_q, c_d;
    logic             busy_q, busy_d;
    logic             day_tick_q, day_tick_d;
    logic [W_HR-1:0]  hh_q, hh_d;
    logic [W_MIN-1:0] mm_q, mm_d;
    logic [W_SEC-1:0] ss_q, ss_d;
    logic [W_HR-1:0]  disp_hh_q;
    logic [W_MIN-1:0] disp_mm_q;
    logic [W_SEC-1:0] disp_ss_q;

    logic [W_AB-1:0]  field_cur;
    logic [W_AB-1:0]  limit_cur;
    logic [W_AB-1:0]  inc_next;
    logic             inc_wrap;
    logic             set_accept;
    logic [W_AB-1:0]  set_limit;
    logic [W_AB-1:0]  set_sat;

    wrap_incr u_wrap_incr (
        .value_i (a_q),
        .limit_i (b_q),
        .next_o  (inc_next),
        .wrap_o  (inc_wrap)
    );

    // Read port of the field register file, zero-extended to the A/B width.
    always_comb begin
        case (s)
            F_SEC:   field_cur = ss_q;
            F_MIN:   field_cur = mm_q;
            F_HR:    field_cur = {1'b0, hh_q};
            default: field_cur = '0;
        endcase
        limit_cur = field_limit(s);
    end

    // A/B/C next state: La beats Ea on A, and a suppressed Ea leaves C alone; Ea beats Kc on C.
    always_comb begin
        a_d = a_q;
        c_d = c_q;
        if (La) begin
            a_d = field_cur;
        end else if (Ea) begin
            a_d = inc_next;
        end
        if (Ea && !La) begin
            c_d = inc_wrap;
        end else if (Kc) begin
            c_d = 1'b0;
        end
        b_d = Lb ? limit_cur : b_q;
    end

    // Sequence status: the hours write always ends the sequence, a lower field ends it when no carry.
    always_comb begin
        busy_d = busy_q;
        if (Kc) begin
            busy_d = 1'b1;
        end else if (Lr && (!c_d || s == F_HR)) begin
            busy_d = 1'b0;
        end
        day_tick_d = Lr && (s == F_HR) && c_d;
    end

    // Set handshake only while idle; over-range values clamp to the field limit.
    always_comb begin
        set_accept = set_valid && set_ready;
        set_limit  = field_limit(set_field);
        set_sat    = (set_value > set_limit) ? set_limit : set_value;
    end

    // Field write port: a set write first, then Lr (the controller never overlaps them on one field).
    always_comb begin
        ss_d = ss_q;
        mm_d = mm_q;
        hh_d = hh_q;
        if (set_accept) begin
            case (set_field)
                F_SEC:   ss_d = set_sat;
                F_MIN:   mm_d = set_sat;
                F_HR:    hh_d = set_sat[W_HR-1:0];
                default: ;
            endcase
        end
        if (Lr) begin
            case (s)
                F_SEC:   ss_d = a_d;
                F_MIN:   mm_d = a_d;
                F_HR:    hh_d = a_d[W_HR-1:0];
                default: ;
            endcase
        end
    end

    // State registers; Er captures the pre-edge time so a same-cycle Lr shows up at the next Er.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= 1'b0;
            busy_q     <= 1'b0;
            day_tick_q <= 1'b0;
            hh_q       <= '0;
            mm_q       <= '0;
            ss_q       <= '0;
            disp_hh_q  <= '0;
            disp_mm_q  <= '0;
            disp_ss_q  <= '0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            busy_q     <= busy_d;
            day_tick_q <= day_tick_d;
            hh_q       <= hh_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            if (Er) begin
                disp_hh_q <= hh_q;
                disp_mm_q <= mm_q;
                disp_ss_q <= ss_q;
            end
        end
    end

    assign set_ready = !busy_q && !Kc;
    assign u         = c_q;
    assign busy      = busy_q;
    assign day_tick  = day_tick_q;
    assign hh        = hh_q;
    assign mm        = mm_q;
    assign ss        = ss_q;
    assign disp_hh   = disp_hh_q;
    assign disp_mm   = disp_mm_q;
    assign disp_ss   = disp_ss_q;

endmodule

// File: tb/tb_time_update_datapath.sv
// tb/tb_time_update_datapath.sv - scoreboard bench for the time-update datapath
module tb_time_update_datapath;

    logic       clk;
    logic       r_reset;
    logic [1:0] r_s;
    logic       r_kc, r_la, r_lb, r_ea, r_lr, r_er;
    logic       r_sv;
    logic [1:0] r_sf;
    logic [5:0] r_sval;

    logic       set_ready, u, busy, day_tick;
    logic [4:0] hh, disp_hh;
    logic [5:0] mm, ss, disp_mm, disp_ss;

    time_update_datapath dut (
        .clk       (clk),
        .reset     (r_reset),
        .s         (r_s),
        .Kc        (r_kc),
        .La        (r_la),
        .Lb        (r_lb),
        .Ea        (r_ea),
        .Lr        (r_lr),
        .Er        (r_er),
        .set_valid (r_sv),
        .set_field (r_sf),
        .set_value (r_sval),
        .set_ready (set_ready),
        .u         (u),
        .busy      (busy),
        .day_tick  (day_tick),
        .hh        (hh),
        .mm        (mm),
        .ss        (ss),
        .disp_hh   (disp_hh),
        .disp_mm   (disp_mm),
        .disp_ss   (disp_ss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int hh, mm, ss, u, busy, dt, dhh, dmm, dss;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: clock time as three integers plus the controller-visible A, B, C.
    int lim[3] = '{59, 59, 23};
    int m_f[3];
    int m_d[3];
    int m_a, m_b, m_c, m_busy, m_dt;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endtask

    task automatic model_step();
        int sel, sf, fv, lim_s, an, bn, cn, bz;
        int nf[3];
        exp_t e;
        sel = int'(r_s);
        sf  = int'(r_sf);
        if (r_reset) begin
            m_f = '{0, 0, 0};
            m_d = '{0, 0, 0};
            m_a = 0; m_b = 0; m_c = 0; m_busy = 0; m_dt = 0;
        end else begin
            fv    = (sel < 3) ? m_f[sel] : 0;
            lim_s = (sel < 3) ? lim[sel] : 0;
            an = m_a; bn = m_b; cn = m_c; bz = m_busy;
            nf = m_f;
            if (r_kc) cn = 0;
            if (r_la) an = fv;
            else if (r_ea) begin
                cn = (m_a == m_b) ? 1 : 0;
                an = (m_a == m_b) ? 0 : (m_a + 1) % 64;
            end
            if (r_lb) bn = lim_s;
            if (r_kc) bz = 1;
            else if (r_lr && (cn == 0 || sel == 2)) bz = 0;
            m_dt = (r_lr && sel == 2 && cn == 1) ? 1 : 0;
            if (r_sv && m_busy == 0 && !r_kc && sf < 3)
                nf[sf] = (int'(r_sval) > lim[sf]) ? lim[sf] : int'(r_sval);
            if (r_lr && sel < 3) nf[sel] = (sel == 2) ? an % 32 : an;
            if (r_er) m_d = m_f;
            m_f = nf;
            m_a = an; m_b = bn; m_c = cn; m_busy = bz;
        end
        e.hh = m_f[2]; e.mm = m_f[1]; e.ss = m_f[0];
        e.u = m_c; e.busy = m_busy; e.dt = m_dt;
        e.dhh = m_d[2]; e.dmm = m_d[1]; e.dss = m_d[0];
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit rst, input int sel, input bit kc, input bit la, input bit lb,
                         input bit ea, input bit lr, input bit er, input bit sv, input int sf,
                         input int sval);
        @(posedge clk);
        #1;
        r_reset = rst;
        r_s     = sel[1:0];
        r_kc    = kc; r_la = la; r_lb = lb; r_ea = ea; r_lr = lr; r_er = er;
        r_sv    = sv;
        r_sf    = sf[1:0];
        r_sval  = sval[5:0];
        model_step();
    endtask

    task automatic idle();
        drive(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_req(input int f, input int v);
        drive(0, 3, 0, 0, 0, 0, 0, 0, 1, f, v);
    endtask

    task automatic set_time(input int h, input int m, input int sec);
        set_req(2, h);
        set_req(1, m);
        set_req(0, sec);
    endtask

    // Controller-like sequence; it follows the model's carry to decide whether to continue.
    task automatic update_seq(input bit er_on_lr, input bit sv, input int sf, input int sval);
        drive(0, 3, 1, 0, 0, 0, 0, 0, sv, sf, sval);
        for (int fld = 0; fld < 3; fld++) begin
            drive(0, fld, 0, 1, 0, 0, 0, 0, sv, sf, sval);
            drive(0, fld, 0, 0, 1, 0, 0, 0, sv, sf, sval);
            drive(0, fld, 0, 0, 0, 1, 1, er_on_lr, sv, sf, sval);
            if (m_c == 0) break;
        end
    endtask

    task automatic random_cycle();
        bit kc, la, lb, ea, lr, er, sv;
        kc = ($urandom % 6) == 0;
        la = ($urandom % 4) == 0;
        lb = ($urandom % 4) == 0;
        ea = ($urandom % 3) == 0;
        lr = ($urandom % 4) == 0;
        er = ($urandom % 4) == 0;
        sv = ($urandom % 3) == 0;
        if (kc) lr = 0;
        if (la && ea) kc = 0;
        if (lr) sv = 0;
        drive(0, $urandom % 4, kc, la, lb, ea, lr, er, sv, $urandom % 4, $urandom % 64);
    endtask

    // Monitor: one expected entry per clock edge that the driver announced.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (exp_q.size() != 0) begin
                #2;
                e = exp_q.pop_front();
                chk("hh", int'(hh), e.hh);
                chk("mm", int'(mm), e.mm);
                chk("ss", int'(ss), e.ss);
                chk("u", int'(u), e.u);
                chk("busy", int'(busy), e.busy);
                chk("day_tick", int'(day_tick), e.dt);
                chk("disp_hh", int'(disp_hh), e.dhh);
                chk("disp_mm", int'(disp_mm), e.dmm);
                chk("disp_ss", int'(disp_ss), e.dss);
                chk("set_ready", int'(set_ready), (e.busy == 0 && !r_kc) ? 1 : 0);
            end
        end
    end

    initial begin
        int h, m, sec;
        r_reset = 1; r_s = 0; r_kc = 0; r_la = 0; r_lb = 0; r_ea = 0; r_lr = 0; r_er = 0;
        r_sv = 0; r_sf = 0; r_sval = 0;

        // Reset with every strobe asserted, then release.
        drive(1, 2, 1, 1, 1, 1, 1, 1, 1, 0, 63);
        drive(1, 2, 1, 1, 1, 1, 1, 1, 1, 0, 63);
        idle();

        // Seconds increment without and with wrap.
        set_req(0, 58);
        update_seq(0, 0, 0, 0);
        set_time(0, 0, 59);
        drive(0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        idle();

        // Full day rollover.
        set_time(23, 59, 59);
        update_seq(1, 0, 0, 0);
        idle();
        drive(0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // Set saturation, set held during busy, set offered in the Kc cycle.
        set_req(1, 63);
        set_req(2, 40);
        set_req(3, 5);
        set_time(1, 2, 59);
        update_seq(0, 1, 1, 33);
        idle();
        drive(0, 3, 1, 0, 0, 0, 0, 0, 1, 0, 7);
        drive(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // La+Ea priority and Kc+Ea carry.
        set_time(4, 12, 5);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        set_req(1, 59);
        drive(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Display latch around Lr, and a no-op Lr with s=3.
        drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_time(10, 20, 30);
        update_seq(1, 0, 0, 0);
        drive(0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle();

        // Randomized mix.
        for (int it = 0; it < 120; it++) begin
            case ($urandom % 5)
                0: begin
                    h   = ($urandom % 2) ? 23 : $urandom % 24;
                    m   = ($urandom % 2) ? 59 : $urandom % 60;
                    sec = ($urandom % 2) ? 59 : $urandom % 64;
                    set_time(h, m, sec);
                    update_seq($urandom % 2, $urandom % 2, $urandom % 4, $urandom % 64);
                end
                1: for (int k = 0; k < 8; k++) random_cycle();
                2: set_req($urandom % 4, $urandom % 64);
                3: update_seq($urandom % 2, 0, 0, 0);
                default: begin
                    if (($urandom % 8) == 0) drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                    else idle();
                end
            endcase
        end

        repeat (3) idle();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #5;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
